// File: rtl/frogger_pkg.sv
// frogger_pkg: constants and types shared by the river-lane blocks.
//   BLOCKSIZE        frog sprite width in pixels
//   X_OFFSET_LEFT    leftmost pixel column of the playfield
//   X_OFFSET_RIGHT   pixel column just past the right edge of the playfield
//   NUM_RIVER_LANES  number of river lanes (0..5)
//   LOGS_PER_LANE    logs tracked per lane
//   LANE_NONE        frog_lane code for bank/road (no river lane)
//   log_lane_t       left edges of the logs in one lane, [log][pixel]
//   rider_state_t    log_rider FSM states
package frogger_pkg;

  localparam logic [9:0] BLOCKSIZE       = 10'd32;
  localparam logic [9:0] X_OFFSET_LEFT   = 10'd96;
  localparam logic [9:0] X_OFFSET_RIGHT  = 10'd544;
  localparam int         NUM_RIVER_LANES = 6;
  localparam int         LOGS_PER_LANE   = 3;
  localparam logic [2:0] LANE_NONE       = 3'd7;

  typedef logic [2:0][9:0] log_lane_t;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    RIDING,
    OFFLOG,
    DROWNED
  } rider_state_t;

endpackage

// File: rtl/log_rider_if.sv
// log_rider_if: bundle between the game logic (master) and log_rider (slave).
//   master drives frog position, lane, log geometry and drown_ack;
//   slave drives on_log, carry_left/right, drown and drowned.
// Handshake: there is no valid/ready pair. drown is a 1-cycle pulse that opens
// a DROWNED episode; drowned stays high until the master raises drown_ack, which
// is consumed on the first rising clk edge where it is seen high in DROWNED.
interface log_rider_if;
  import frogger_pkg::*;

  logic [9:0]                            frog_x;
  logic [2:0]                            frog_lane;
  log_lane_t [NUM_RIVER_LANES-1:0]       log_x;
  logic [NUM_RIVER_LANES-1:0][9:0]       log_len;
  logic                                  drown_ack;
  logic                                  on_log;
  logic                                  carry_left;
  logic                                  carry_right;
  logic                                  drown;
  logic                                  drowned;

  modport master (
    output frog_x, frog_lane, log_x, log_len, drown_ack,
    input  on_log, carry_left, carry_right, drown, drowned
  );

  modport slave (
    input  frog_x, frog_lane, log_x, log_len, drown_ack,
    output on_log, carry_left, carry_right, drown, drowned
  );

endinterface

// File: rtl/log_hit_check.sv
// log_hit_check: combinational hit test for one river lane.
//   lane_x      left edges of the lane's logs
//   len         log length in this lane, pixels
//   hit_pt      frog hit point (frog_x + centre offset), 11 bits so it never wraps
//   lane_valid  0 forces a miss (frog not in a river lane)
//   hit         some log covers hit_pt
//   hit_idx     lowest-index log that covers hit_pt
module log_hit_check
  import frogger_pkg::*;
(
  input  log_lane_t   lane_x,
  input  logic [9:0]  len,
  input  logic [10:0] hit_pt,
  input  logic        lane_valid,
  output logic        hit,
  output logic [1:0]  hit_idx
);

  // Scan from the highest index down so the lowest-index hit is written last.
  always_comb begin
    hit     = 1'b0;
    hit_idx = 2'd0;
    for (int k = LOGS_PER_LANE - 1; k >= 0; k--) begin
      if (lane_valid &&
          ({1'b0, lane_x[k]} <= hit_pt) &&
          (hit_pt < ({1'b0, lane_x[k]} + {1'b0, len}))) begin
        hit     = 1'b1;
        hit_idx = 2'(k);
      end
    end
  end

endmodule

// File: rtl/log_rider.sv
// log_rider: decides whether the frog stands on a log in its river lane,
// emits carry pulses as the ridden log moves, and signals drowning.
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   bus          log_rider_if.slave (frog/log inputs, rider outputs)
//   state_dbg    current FSM state
// Parameters: GRACE_CYCLES, DROWN_CYCLES (24-bit), CENTER_OFS (hit point offset).
// Build option: LOG_RIDER_EDGE_KILL_EN drowns a riding frog carried past the
// playfield edges; without it the frog rides until the log leaves it.
// All outputs are registered: they reflect the inputs of the previous cycle.
module log_rider
  import frogger_pkg::*;
#(
  parameter logic [23:0] GRACE_CYCLES = 24'd2000,
  parameter logic [23:0] DROWN_CYCLES = 24'd500,
  parameter logic [9:0]  CENTER_OFS   = 10'd16
) (
  input  logic          clk,
  input  logic          reset,
  log_rider_if.slave    bus,
  output rider_state_t  state_dbg
);

  rider_state_t state_q, state_n;
  logic [23:0]  grace_q, grace_n;
  logic [23:0]  off_q, off_n;
  logic [2:0]   lane_q, lane_n;
  logic [1:0]   idx_q, idx_n;
  logic [9:0]   prev_x_q, prev_x_n;
  logic         on_log_n, carry_left_n, carry_right_n, drown_n, drowned_n;

  logic         lane_valid;
  logic [2:0]   lane_sel;
  log_lane_t    mux_x;
  logic [10:0]  hit_pt;
  logic         hit;
  logic [1:0]   hit_idx;
  logic [9:0]   cur_x;
  logic [9:0]   delta;
  logic         lane_changed;

  assign lane_valid   = bus.frog_lane < 3'(NUM_RIVER_LANES);
  assign lane_sel     = lane_valid ? bus.frog_lane : 3'd0;
  assign mux_x        = bus.log_x[lane_sel];
  assign hit_pt       = {1'b0, bus.frog_x} + {1'b0, CENTER_OFS};
  assign cur_x        = mux_x[idx_q];
  assign delta        = cur_x - prev_x_q;
  assign lane_changed = bus.frog_lane != lane_q;
  assign state_dbg    = state_q;

  log_hit_check u_hit (
    .lane_x     (mux_x),
    .len        (bus.log_len[lane_sel]),
    .hit_pt     (hit_pt),
    .lane_valid (lane_valid),
    .hit        (hit),
    .hit_idx    (hit_idx)
  );

  always_comb begin
    state_n       = state_q;
    grace_n       = grace_q;
    off_n         = off_q;
    lane_n        = lane_q;
    idx_n         = idx_q;
    prev_x_n      = prev_x_q;
    on_log_n      = 1'b0;
    carry_left_n  = 1'b0;
    carry_right_n = 1'b0;
    drown_n       = 1'b0;
    drowned_n     = 1'b0;

    // A lane change overrides everything else in the active states,
    // including a log move in the same cycle (no carry is emitted).
    if ((state_q == SETTLE || state_q == RIDING || state_q == OFFLOG) && lane_changed) begin
      if (lane_valid) begin
        state_n = SETTLE;
        grace_n = 24'd0;
        lane_n  = bus.frog_lane;
      end else begin
        state_n = IDLE;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (lane_valid) begin
            state_n = SETTLE;
            grace_n = 24'd0;
            lane_n  = bus.frog_lane;
          end
        end

        SETTLE: begin
          if (hit) begin
            state_n  = RIDING;
            idx_n    = hit_idx;
            prev_x_n = mux_x[hit_idx];
            on_log_n = 1'b1;
          end else if (grace_q + 24'd1 >= GRACE_CYCLES) begin
            state_n = OFFLOG;
            grace_n = GRACE_CYCLES;
            off_n   = 24'd0;
          end else begin
            grace_n = grace_q + 24'd1;
          end
        end

        RIDING: begin
          prev_x_n = cur_x;
`ifdef LOG_RIDER_EDGE_KILL_EN
          if ((bus.frog_x < X_OFFSET_LEFT) ||
              (({1'b0, bus.frog_x} + {1'b0, BLOCKSIZE}) > {1'b0, X_OFFSET_RIGHT})) begin
            state_n   = DROWNED;
            drown_n   = 1'b1;
            drowned_n = 1'b1;
          end else
`endif
          // A step larger than one pixel means the log wrapped around the screen.
          if ((delta != 10'd0 && delta != 10'd1 && delta != 10'h3FF) ||
              !hit || hit_idx != idx_q) begin
            state_n = OFFLOG;
            off_n   = 24'd0;
          end else begin
            on_log_n      = 1'b1;
            carry_right_n = delta == 10'd1;
            carry_left_n  = delta == 10'h3FF;
          end
        end

        OFFLOG: begin
          if (hit) begin
            state_n  = RIDING;
            idx_n    = hit_idx;
            prev_x_n = mux_x[hit_idx];
            off_n    = 24'd0;
            on_log_n = 1'b1;
          end else if (off_q + 24'd1 >= DROWN_CYCLES) begin
            state_n   = DROWNED;
            off_n     = DROWN_CYCLES;
            drown_n   = 1'b1;
            drowned_n = 1'b1;
          end else begin
            off_n = off_q + 24'd1;
          end
        end

        DROWNED: begin
          if (bus.drown_ack) begin
            state_n = IDLE;
          end else begin
            drowned_n = 1'b1;
          end
        end

        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      grace_q         <= 24'd0;
      off_q           <= 24'd0;
      lane_q          <= 3'd0;
      idx_q           <= 2'd0;
      prev_x_q        <= 10'd0;
      bus.on_log      <= 1'b0;
      bus.carry_left  <= 1'b0;
      bus.carry_right <= 1'b0;
      bus.drown       <= 1'b0;
      bus.drowned     <= 1'b0;
    end else begin
      state_q         <= state_n;
      grace_q         <= grace_n;
      off_q           <= off_n;
      lane_q          <= lane_n;
      idx_q           <= idx_n;
      prev_x_q        <= prev_x_n;
      bus.on_log      <= on_log_n;
      bus.carry_left  <= carry_left_n;
      bus.carry_right <= carry_right_n;
      bus.drown       <= drown_n;
      bus.drowned     <= drowned_n;
    end
  end

endmodule

// File: tb/tb_log_rider.sv
// tb_log_rider: directed bench for log_rider with default parameters.
module tb_log_rider;
  import frogger_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  rider_state_t state_dbg;
  int           n_checks = 0;
  int           n_errors = 0;
  int           n_found;
  int           n_offlog;
  int           n_pulses;

  log_rider_if bus();

  log_rider u_dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // checker
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // driver: advance one clock, land 1 time unit past the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic ol, input logic cl,
                            input logic cr, input logic dn, input logic dd);
    check({tag, ".on_log"},      32'(bus.on_log),      32'(ol));
    check({tag, ".carry_left"},  32'(bus.carry_left),  32'(cl));
    check({tag, ".carry_right"}, 32'(bus.carry_right), 32'(cr));
    check({tag, ".drown"},       32'(bus.drown),       32'(dn));
    check({tag, ".drowned"},     32'(bus.drowned),     32'(dd));
  endtask

  initial begin
    reset         = 1'b1;
    bus.frog_x    = 10'd0;
    bus.frog_lane = LANE_NONE;
    bus.log_x     = '0;
    bus.log_len   = '0;
    bus.drown_ack = 1'b0;
    step();
    step();
    check("reset.state", 32'(state_dbg), 32'(IDLE));
    check_outs("reset", 0, 0, 0, 0, 0);

    // lane 1: immediate hit, then a +1 log step
    reset            = 1'b0;
    bus.log_len[1]   = 10'd96;
    bus.log_x[1][0]  = 10'd200;
    bus.frog_x       = 10'd220;
    bus.frog_lane    = 3'd1;
    step();
    check("l1.settle", 32'(state_dbg), 32'(SETTLE));
    step();
    check("l1.riding", 32'(state_dbg), 32'(RIDING));
    check_outs("l1.ride", 1, 0, 0, 0, 0);
    bus.log_x[1][0] = 10'd201;
    step();
    check_outs("l1.step", 1, 0, 1, 0, 0);
    step();
    check_outs("l1.hold", 1, 0, 0, 0, 0);

    // reset while riding
    reset = 1'b1;
    step();
    check("rst_ride.state", 32'(state_dbg), 32'(IDLE));
    check_outs("rst_ride", 0, 0, 0, 0, 0);
    reset         = 1'b0;
    bus.frog_lane = LANE_NONE;
    step();
    check("rst_ride.idle", 32'(state_dbg), 32'(IDLE));

    // lane 0: log stepping left, frog following
    bus.log_len[0]  = 10'd96;
    bus.log_x[0][0] = 10'd300;
    bus.frog_x      = 10'd310;
    bus.frog_lane   = 3'd0;
    step();
    step();
    check("l0.riding", 32'(state_dbg), 32'(RIDING));
    n_pulses = 0;
    for (int i = 0; i < 8; i++) begin
      bus.log_x[0][0] = bus.log_x[0][0] - 10'd1;
      bus.frog_x      = bus.frog_x - 10'd1;
      step();
      check("l0.carry_right", 32'(bus.carry_right), 32'd0);
      if (bus.carry_left) n_pulses++;
    end
    check("l0.left_count", 32'(n_pulses), 32'd8);
    step();
    check_outs("l0.still", 1, 0, 0, 0, 0);

    // lane change in the same cycle as a log move: lane change wins
    bus.log_x[0][0] = bus.log_x[0][0] - 10'd1;
    bus.frog_lane   = 3'd2;
    step();
    check("lchg.state", 32'(state_dbg), 32'(SETTLE));
    check_outs("lchg", 0, 0, 0, 0, 0);

    // lane 2 is empty: grace window, then off-log debounce, then drown
    // lane 2 entered at the edge just taken (count 1)
    n_found  = 0;
    n_offlog = 0;
    n_pulses = 0;
    for (int n = 2; n <= 3000; n++) begin
      step();
      if (n_offlog == 0 && state_dbg == OFFLOG) n_offlog = n;
      if (bus.drown) begin
        n_found = n;
        break;
      end
    end
    check("drown.offlog_at", 32'(n_offlog), 32'd2001);
    check("drown.at", 32'(n_found), 32'd2501);
    check_outs("drown.entry", 0, 0, 0, 1, 1);
    bus.frog_lane = LANE_NONE;
    for (int i = 0; i < 3; i++) begin
      step();
      if (bus.drown) n_pulses++;
    end
    check("drown.extra_pulses", 32'(n_pulses), 32'd0);
    check("drown.held", 32'(bus.drowned), 32'd1);
    check("drown.state", 32'(state_dbg), 32'(DROWNED));
    bus.drown_ack = 1'b1;
    step();
    bus.drown_ack = 1'b0;
    check("ack.state", 32'(state_dbg), 32'(IDLE));
    check_outs("ack", 0, 0, 0, 0, 0);

    // lane 3: log wraps 32 -> 544 under the frog
    bus.log_len[3]  = 10'd128;
    bus.log_x[3][0] = 10'd32;
    bus.frog_x      = 10'd120;
    bus.frog_lane   = 3'd3;
    step();
    step();
    check("wrap.riding", 32'(state_dbg), 32'(RIDING));
    bus.log_x[3][0] = 10'd544;
    step();
    check("wrap.state", 32'(state_dbg), 32'(OFFLOG));
    check_outs("wrap", 0, 0, 0, 0, 0);
    n_found = 0;
    for (int n = 1; n <= 600; n++) begin
      step();
      if (bus.drown) begin
        n_found = n;
        break;
      end
    end
    check("wrap.drown_at", 32'(n_found), 32'd500);
    bus.frog_lane = LANE_NONE;
    bus.drown_ack = 1'b1;
    step();
    bus.drown_ack = 1'b0;
    check("wrap.ack", 32'(state_dbg), 32'(IDLE));

    // lane 4: frog carried to x=95, past the left playfield edge
    bus.log_len[4]  = 10'd96;
    bus.log_x[4][0] = 10'd90;
    bus.frog_x      = 10'd96;
    bus.frog_lane   = 3'd4;
    step();
    step();
    check("edge.riding", 32'(state_dbg), 32'(RIDING));
    bus.log_x[4][0] = 10'd89;
    bus.frog_x      = 10'd95;
    step();
`ifdef LOG_RIDER_EDGE_KILL_EN
    check("edge.state", 32'(state_dbg), 32'(DROWNED));
    check_outs("edge", 0, 0, 0, 1, 1);
`else
    check("edge.state", 32'(state_dbg), 32'(RIDING));
    check_outs("edge", 1, 1, 0, 0, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
